// File: rtl/int_arith_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// int_arith_pkg : shared types and constants for the integer arithmetic unit
// Rev 1.0
// ----------------------------------------------------------------------------
package int_arith_pkg;

   localparam int DIV_WIDTH = 4;

   // Quotient reported for a zero divisor, sliced to the operand width by users.
   localparam logic [63:0] DIV_ZERO_QUOT = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } arith_state_t;

   // Counter width able to index WIDTH iterations; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage : int_arith_pkg
`default_nettype wire

// File: rtl/int_divider_div_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_step : one combinational restoring shift-subtract iteration
// Rev 1.0
// ----------------------------------------------------------------------------
module div_step
   import int_arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   i_r,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH:0]   o_r_next,
   output logic [WIDTH-1:0] o_q_next
);

   logic [WIDTH:0] w_r_sh;
   logic           w_ge;

   always_comb begin
      w_r_sh = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
      // The partial remainder stays below D, so its top bit only matters if that ever breaks.
      w_ge     = i_r[WIDTH] | (w_r_sh >= {1'b0, i_d});
      o_r_next = w_ge ? (w_r_sh - {1'b0, i_d}) : w_r_sh;
      o_q_next = {i_q[WIDTH-2:0], w_ge};
   end

endmodule : div_step
`default_nettype wire

// File: rtl/int_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// int_divider : sequential unsigned restoring divider, one quotient bit per clock
// Rev 1.0
// ----------------------------------------------------------------------------
module int_divider
   import int_arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int                 c_cnt_w   = cnt_width(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   c_dz_quot = DIV_ZERO_QUOT[WIDTH-1:0];

   arith_state_t       r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_q,     w_q_nxt;
   logic [WIDTH:0]     r_r,     w_r_nxt;
   logic [WIDTH-1:0]   r_d,     w_d_nxt;
   logic [c_cnt_w-1:0] r_cnt,   w_cnt_nxt;
   logic [WIDTH-1:0]   r_quot,  w_quot_nxt;
   logic [WIDTH-1:0]   r_rem,   w_rem_nxt;
   logic               r_busy,  w_busy_nxt;
   logic               r_done,  w_done_nxt;
   logic               r_dz,    w_dz_nxt;

   logic [WIDTH:0]     w_r_step;
   logic [WIDTH-1:0]   w_q_step;

   div_step #(
      .WIDTH    (WIDTH)
   ) u_step (
      .i_r      (r_r),
      .i_q      (r_q),
      .i_d      (r_d),
      .o_r_next (w_r_step),
      .o_q_next (w_q_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_r     <= '0;
         r_d     <= '0;
         r_cnt   <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_r     <= w_r_nxt;
         r_d     <= w_d_nxt;
         r_cnt   <= w_cnt_nxt;
         r_quot  <= w_quot_nxt;
         r_rem   <= w_rem_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_dz    <= w_dz_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_r_nxt     = r_r;
      w_d_nxt     = r_d;
      w_cnt_nxt   = r_cnt;
      w_quot_nxt  = r_quot;
      w_rem_nxt   = r_rem;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_dz_nxt    = r_dz;

      unique case (r_state)
         // DONE accepts exactly like IDLE so operations can run back-to-back.
         S_IDLE, S_DONE: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            if (start) begin
               if (divisor != '0) begin
                  w_q_nxt     = dividend;
                  w_d_nxt     = divisor;
                  w_r_nxt     = '0;
                  w_cnt_nxt   = '0;
                  w_busy_nxt  = 1'b1;
                  w_dz_nxt    = 1'b0;
                  w_state_nxt = S_RUN;
               end else begin
                  w_quot_nxt  = c_dz_quot;
                  w_rem_nxt   = dividend;
                  w_dz_nxt    = 1'b1;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
         end

         S_RUN: begin
            w_q_nxt   = w_q_step;
            w_r_nxt   = w_r_step;
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
            if (r_cnt == c_last) begin
               w_quot_nxt  = w_q_step;
               w_rem_nxt   = w_r_step[WIDTH-1:0];
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign quotient    = r_quot;
   assign remainder   = r_rem;
   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dz;

endmodule : int_divider
`default_nettype wire

// File: tb/tb_int_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_int_divider : randomized and directed bench with a cycle-level reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_int_divider;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] dividend = '0;
   logic [WIDTH-1:0] divisor = '0;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   int n_chk = 0;
   int n_err = 0;

   int_divider #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted op finishes a fixed number of edges later
   // with results from plain integer division.
   int               m_left = 0;
   logic             m_busy = 1'b0;
   logic             m_done = 1'b0;
   logic             m_dz   = 1'b0;
   logic [WIDTH-1:0] m_quot = '0;
   logic [WIDTH-1:0] m_rem  = '0;
   logic [WIDTH-1:0] p_q    = '0;
   logic [WIDTH-1:0] p_r    = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_dz   <= 1'b0;
         m_quot <= '0;
         m_rem  <= '0;
      end else if (m_left != 0) begin
         m_left <= m_left - 1;
         m_done <= (m_left == 1);
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_quot <= p_q;
            m_rem  <= p_r;
         end
      end else begin
         m_done <= 1'b0;
         m_busy <= 1'b0;
         if (start) begin
            if (divisor == 0) begin
               m_done <= 1'b1;
               m_dz   <= 1'b1;
               m_quot <= '1;
               m_rem  <= dividend;
            end else begin
               m_left <= WIDTH;
               m_busy <= 1'b1;
               m_dz   <= 1'b0;
               p_q    <= dividend / divisor;
               p_r    <= dividend % divisor;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_dz", 32'(div_by_zero), 32'(m_dz));
      chk("cyc_quot", 32'(quotient), 32'(m_quot));
      chk("cyc_rem", 32'(remainder), 32'(m_rem));
   end

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after the accepting edge until done is seen; ends on that negedge.
   task automatic wait_done(output int lat);
      bit ok = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         lat++;
         dividend = WIDTH'($urandom);
         divisor  = WIDTH'($urandom);
      end
      if (!ok) chk("done_timeout", 32'(0), 32'(1));
   endtask

   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit b2b, output int lat);
      if (b2b) begin
         start    = 1'b1;
         dividend = a;
         divisor  = b;
         @(posedge clk);
         #1;
         start = 1'b0;
      end else begin
         issue(a, b);
      end
      wait_done(lat);
   endtask

   task automatic directed(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit b2b, input int eq, input int er, input int edz, input int elat);
      int lat;
      do_op(a, b, b2b, lat);
      chk({name, "_lat"}, 32'(lat), 32'(elat));
      chk({name, "_q"}, 32'(quotient), 32'(eq));
      chk({name, "_r"}, 32'(remainder), 32'(er));
      chk({name, "_dz"}, 32'(div_by_zero), 32'(edz));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   initial begin
      int lat;
      logic [WIDTH-1:0] a, b;
      bit b2b;

      @(negedge clk);
      chk("rst_quot", 32'(quotient), 32'(0));
      chk("rst_rem", 32'(remainder), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_dz", 32'(div_by_zero), 32'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      directed("d15_3", 4'd15, 4'd3, 1'b0, 5, 0, 0, 4);
      directed("d7_2", 4'd7, 4'd2, 1'b0, 3, 1, 0, 4);
      directed("d3_7", 4'd3, 4'd7, 1'b0, 0, 3, 0, 4);
      directed("d15_15", 4'd15, 4'd15, 1'b0, 1, 0, 0, 4);
      directed("d0_3", 4'd0, 4'd3, 1'b0, 0, 0, 0, 4);
      directed("d5_0", 4'd5, 4'd0, 1'b0, 15, 5, 1, 0);

      // A start pulse during RUN must be ignored.
      issue(4'd12, 4'd5);
      @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = 4'd9;
      divisor  = 4'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat);
      chk("busy_ign_lat", 32'(lat), 32'(2));
      chk("busy_ign_q", 32'(quotient), 32'(2));
      chk("busy_ign_r", 32'(remainder), 32'(2));

      // Asynchronous reset in the middle of an operation.
      issue(4'd10, 4'd3);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_quot", 32'(quotient), 32'(0));
      chk("arst_rem", 32'(remainder), 32'(0));
      chk("arst_busy", 32'(busy), 32'(0));
      chk("arst_done", 32'(done), 32'(0));
      chk("arst_dz", 32'(div_by_zero), 32'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      directed("d6_4", 4'd6, 4'd4, 1'b0, 1, 2, 0, 4);

      directed("d14_4", 4'd14, 4'd4, 1'b0, 3, 2, 0, 4);
      directed("b2b_13_2", 4'd13, 4'd2, 1'b1, 6, 1, 0, 4);
      directed("b2b_9_0", 4'd9, 4'd0, 1'b1, 15, 9, 1, 0);
      directed("b2b_11_3", 4'd11, 4'd3, 1'b1, 3, 2, 0, 4);

      for (int i = 0; i < 40; i++) begin
         a   = WIDTH'($urandom_range(0, 15));
         b   = ($urandom_range(0, 5) == 0) ? WIDTH'(0) : WIDTH'($urandom_range(1, 15));
         b2b = 1'($urandom_range(0, 1));
         if (!b2b) repeat ($urandom_range(0, 2)) @(posedge clk);
         do_op(a, b, b2b, lat);
         chk("rnd_lat", 32'(lat), (b == 0) ? 32'(0) : 32'(WIDTH));
         chk("rnd_q", 32'(quotient), (b == 0) ? 32'(15) : 32'(a / b));
         chk("rnd_r", 32'(remainder), (b == 0) ? 32'(a) : 32'(a % b));
         chk("rnd_dz", 32'(div_by_zero), 32'(b == 0));
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_int_divider
`default_nettype wire
